// File: rtl/grf_pkg.sv
// Shared defaults for the multi-port general register file.
package grf_pkg;

  localparam int unsigned GRF_DATA_W = 32;
  localparam int unsigned GRF_NREGS  = 32;
  localparam int unsigned ZERO_ADDR  = 0;

endpackage

// File: rtl/mp_reg_file_if.sv
// Read, write, PC-trace and issue signals of the multi-port register file.
interface mp_reg_file_if
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W,
  parameter int unsigned NREGS  = GRF_NREGS,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NWR*32-1:0]     wr_pc;
  logic                  issue_en;
  logic [AW-1:0]         issue_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_pc, issue_en, issue_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, issue_en, issue_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/rf_wr_arbiter.sv
// Selects the winning write port for one address; the highest enabled port index wins.
module rf_wr_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NWR    = 2
) (
  input  logic [AW-1:0]         i_addr,
  input  logic [NWR-1:0]        i_wr_en,
  input  logic [NWR*AW-1:0]     i_wr_addr,
  input  logic [NWR*DATA_W-1:0] i_wr_data,
  output logic                  o_hit,
  output logic [DATA_W-1:0]     o_data
);

  // Ascending scan: a later (higher) port overrides an earlier match.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mp_reg_file.sv
// Multi-port register file with write-through bypass and pending-write scoreboard.
// Define GRF_TRACE_EN for a simulation-only trace of every effective write.
module mp_reg_file
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W   = GRF_DATA_W,
  parameter int unsigned NREGS    = GRF_NREGS,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  mp_reg_file_if.slave      bus
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [DATA_W-1:0] w_regs    [NREGS];
  logic [DATA_W-1:0] w_st_data [NREGS];
  logic [NREGS-1:0]  w_st_hit;
  logic [NREGS-1:0]  r_busy;
  logic [NREGS-1:0]  w_busy_d;

  // The PC only feeds the optional trace.
  logic w_unused_pc;
  assign w_unused_pc = ^bus.wr_pc;

  for (genvar a = 0; a < NREGS; a++) begin : g_reg
    rf_wr_arbiter #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .NWR    (NWR)
    ) u_st_arb (
      .i_addr    (AW'(a)),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_hit     (w_st_hit[a]),
      .o_data    (w_st_data[a])
    );

    if ((ZERO_REG != 0) && (a == ZERO_ADDR)) begin : g_zero
      logic w_unused_zero;
      assign w_unused_zero = ^w_st_data[a];
      assign w_regs[a]     = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] r_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_reg <= '0;
        end else if (w_st_hit[a]) begin
          r_reg <= w_st_data[a];
        end
      end
      assign w_regs[a] = r_reg;
    end
  end

  // A new producer's set overrides a same-cycle writeback clear.
  always_comb begin
    w_busy_d = r_busy & ~w_st_hit;
    if (bus.issue_en) begin
      w_busy_d[bus.issue_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_busy_d[ZERO_ADDR] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]     w_rd_addr;
    logic              w_byp_hit;
    logic [DATA_W-1:0] w_byp_data;
    logic              w_rd_zero;

    assign w_rd_addr = bus.rd_addr[k*AW +: AW];

    rf_wr_arbiter #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .NWR    (NWR)
    ) u_byp_arb (
      .i_addr    (w_rd_addr),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_hit     (w_byp_hit),
      .o_data    (w_byp_data)
    );

    assign w_rd_zero = (ZERO_REG != 0) && (w_rd_addr == AW'(ZERO_ADDR));

    assign bus.rd_data[k*DATA_W +: DATA_W] = w_rd_zero ? '0 :
                                             w_byp_hit ? w_byp_data : w_regs[w_rd_addr];
    assign bus.rd_busy[k] = r_busy[w_rd_addr] & ~w_byp_hit;
  end

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NWR; p++) begin
        logic          eff;
        logic [AW-1:0] addr;
        addr = bus.wr_addr[p*AW +: AW];
        eff  = bus.wr_en[p] && !((ZERO_REG != 0) && (addr == AW'(ZERO_ADDR)));
        for (int q = p + 1; q < NWR; q++) begin
          if (bus.wr_en[q] && (bus.wr_addr[q*AW +: AW] == addr)) eff = 1'b0;
        end
        if (eff) begin
          $display("@%h: $%d <= %h", bus.wr_pc[p*32 +: 32], addr,
                   bus.wr_data[p*DATA_W +: DATA_W]);
        end
      end
    end
  end
`else
  // Trace disabled: no simulation-only code.
`endif

endmodule

// File: tb/tb_mp_reg_file.sv
// Directed bench for mp_reg_file: stimulus queues expectations, a negedge monitor checks them.
module tb_mp_reg_file;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;
  localparam int unsigned AW  = 5;

  logic clk;
  logic reset;

  mp_reg_file_if #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) bus ();

  mp_reg_file #(
    .DATA_W   (DW),
    .NREGS    (NR),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: everything queued during this cycle is checked at the falling edge.
  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      exp_t e;
      logic [31:0] act_d;
      logic        act_b;
      e     = q_exp.pop_front();
      act_d = bus.rd_data[e.port*DW +: DW];
      act_b = bus.rd_busy[e.port];
      n_tests++;
      if (act_d !== e.data) begin
        n_fail++;
        $display("FAIL %s data port%0d: got %h expected %h", e.name, e.port, act_d, e.data);
      end
      n_tests++;
      if (act_b !== e.busy) begin
        n_fail++;
        $display("FAIL %s busy port%0d: got %b expected %b", e.name, e.port, act_b, e.busy);
      end
    end
  end

  task automatic idle();
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.wr_pc      = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.rd_addr    = '0;
  endtask

  task automatic set_wr(input int p, input int addr, input logic [31:0] data);
    bus.wr_en[p]              = 1'b1;
    bus.wr_addr[p*AW +: AW]   = AW'(addr);
    bus.wr_data[p*DW +: DW]   = data;
    bus.wr_pc[p*32 +: 32]     = 32'h1000 + 32'(p * 4);
  endtask

  task automatic set_issue(input int addr);
    bus.issue_en   = 1'b1;
    bus.issue_addr = AW'(addr);
  endtask

  task automatic expect_rd(input string name, input int k, input int addr,
                           input logic [31:0] data, input logic busy);
    exp_t e;
    bus.rd_addr[k*AW +: AW] = AW'(addr);
    e.name = name;
    e.port = k;
    e.data = data;
    e.busy = busy;
    q_exp.push_back(e);
  endtask

  // Let the monitor sample, then advance to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    expect_rd("reset_r5", 0, 5, 32'h0, 1'b0);
    expect_rd("reset_r31", 1, 31, 32'h0, 1'b0);
    step();

    // 1: reset discards a pending write and issue, and clears stored state
    idle(); set_wr(0, 5, 32'h1234); set_issue(10);
    step();
    idle(); reset = 1'b1; set_wr(0, 6, 32'hFF); set_issue(11);
    step();
    reset = 1'b0;
    idle();
    expect_rd("rst_r5", 0, 5, 32'h0, 1'b0);
    expect_rd("rst_r6", 1, 6, 32'h0, 1'b0);
    step();
    idle();
    expect_rd("rst_busy_r10", 0, 10, 32'h0, 1'b0);
    expect_rd("rst_busy_r11", 1, 11, 32'h0, 1'b0);
    step();

    // 2: same-cycle bypass, then stored value
    idle(); set_wr(0, 3, 32'hDEAD);
    expect_rd("byp_r3", 0, 3, 32'hDEAD, 1'b0);
    expect_rd("byp_other", 1, 5, 32'h0, 1'b0);
    step();
    idle();
    expect_rd("stored_r3", 0, 3, 32'hDEAD, 1'b0);
    step();

    // 3: write conflict, higher port wins
    idle(); set_wr(0, 7, 32'h1); set_wr(1, 7, 32'h2);
    expect_rd("conf_byp_r7", 0, 7, 32'h2, 1'b0);
    expect_rd("conf_byp_r7b", 1, 7, 32'h2, 1'b0);
    step();
    idle();
    expect_rd("conf_st_r7", 1, 7, 32'h2, 1'b0);
    step();

    // 4: zero register
    idle(); set_wr(1, 0, 32'hFFFFFFFF); set_issue(0);
    expect_rd("zero_byp", 0, 0, 32'h0, 1'b0);
    step();
    idle();
    expect_rd("zero_st", 0, 0, 32'h0, 1'b0);
    step();

    // 5: scoreboard issue / writeback
    idle(); set_issue(9);
    expect_rd("sb_issue_cyc", 0, 9, 32'h0, 1'b0);
    step();
    idle();
    expect_rd("sb_busy", 0, 9, 32'h0, 1'b1);
    step();
    idle(); set_wr(1, 9, 32'h55);
    expect_rd("sb_wb_byp", 0, 9, 32'h55, 1'b0);
    expect_rd("sb_other", 1, 3, 32'hDEAD, 1'b0);
    step();
    idle();
    expect_rd("sb_cleared", 0, 9, 32'h55, 1'b0);
    step();

    // 6: issue and write to the same address in one cycle
    idle(); set_issue(4); set_wr(0, 4, 32'h77);
    expect_rd("iw_byp_r4", 0, 4, 32'h77, 1'b0);
    step();
    idle();
    expect_rd("iw_st_r4", 0, 4, 32'h77, 1'b1);
    expect_rd("iw_r9", 1, 9, 32'h55, 1'b0);
    step();

    // Write to non-busy register stays non-busy; two ports to distinct registers
    idle(); set_wr(0, 12, 32'hA5A5A5A5); set_wr(1, 13, 32'h5A5A5A5A);
    step();
    idle();
    expect_rd("nb_r12", 0, 12, 32'hA5A5A5A5, 1'b0);
    expect_rd("nb_r13", 1, 13, 32'h5A5A5A5A, 1'b0);
    step();

    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, 0 required", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
